// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage RV32I pipeline: stall/flush/forward decode,
// data-memory wait FSM with timeout, and saturating hazard performance counters.
module hazard_control_unit #(
  parameter int unsigned MISS_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 16,
  parameter logic [2:0]  LOAD_SRC     = 3'b001
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [4:0]       iRs1D,
  input  logic [4:0]       iRs2D,
  input  logic [4:0]       iRs1E,
  input  logic [4:0]       iRs2E,
  input  logic [4:0]       iRdE,
  input  logic [2:0]       iResultSrcE,
  input  logic             iRegWriteEnE,
  input  logic [4:0]       iRdM,
  input  logic             iRegWriteEnM,
  input  logic [4:0]       iRdW,
  input  logic             iRegWriteEnW,
  input  logic             iBranchTakenE,
  input  logic             iMemReqM,
  input  logic             iMemReadyM,
  output logic             oStallF,
  output logic             oStallD,
  output logic             oStallE,
  output logic             oStallM,
  output logic             oFlushD,
  output logic             oFlushE,
  output logic             oFlushW,
  output logic [1:0]       oForwardAE,
  output logic [1:0]       oForwardBE,
  output logic             oMemTimeout,
  output logic [CNT_W-1:0] oStallCycles,
  output logic [CNT_W-1:0] oFlushCount
);

  localparam int unsigned      WAIT_W    = $clog2(MISS_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MISS_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic mem_stall;
  logic mem_abandon;
  logic load_use;

  // E-stage operand forwarding; M result is younger and wins over W
  always_comb begin
    oForwardAE = 2'b00;
    oForwardBE = 2'b00;
    if (!iRst) begin
      if (iRegWriteEnM && iRdM != 5'd0 && iRdM == iRs1E)      oForwardAE = 2'b10;
      else if (iRegWriteEnW && iRdW != 5'd0 && iRdW == iRs1E) oForwardAE = 2'b01;
      if (iRegWriteEnM && iRdM != 5'd0 && iRdM == iRs2E)      oForwardBE = 2'b10;
      else if (iRegWriteEnW && iRdW != 5'd0 && iRdW == iRs2E) oForwardBE = 2'b01;
    end
  end

  always_comb begin
    mem_stall   = 1'b0;
    mem_abandon = 1'b0;
    if (state_q == RUN) begin
      mem_stall = iMemReqM && !iMemReadyM;
    end else if (!iMemReadyM) begin
      mem_stall   = wait_cnt_q < WAIT_LAST;
      mem_abandon = !(wait_cnt_q < WAIT_LAST);
    end
    load_use = (iResultSrcE == LOAD_SRC) && iRegWriteEnE && (iRdE != 5'd0) &&
               ((iRdE == iRs1D) || (iRdE == iRs2D));
  end

  // Stall/flush priority: memory wait, then branch redirect, then load-use bubble
  always_comb begin
    oStallF = 1'b0;
    oStallD = 1'b0;
    oStallE = 1'b0;
    oStallM = 1'b0;
    oFlushD = 1'b0;
    oFlushE = 1'b0;
    oFlushW = 1'b0;
    if (iRst) begin
      oFlushD = 1'b1;
      oFlushE = 1'b1;
      oFlushW = 1'b1;
    end else begin
      if (mem_stall) begin
        oStallF = 1'b1;
        oStallD = 1'b1;
        oStallE = 1'b1;
        oStallM = 1'b1;
        oFlushW = 1'b1;
      end else if (iBranchTakenE) begin
        oFlushD = 1'b1;
        oFlushE = 1'b1;
      end else if (load_use) begin
        oStallF = 1'b1;
        oStallD = 1'b1;
        oFlushE = 1'b1;
      end
      // Abandoned access: squash whatever M would hand to W
      if (mem_abandon) oFlushW = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      RUN: begin
        if (iMemReqM && !iMemReadyM) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (iMemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LAST) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          state_d       = RUN;
          wait_cnt_d    = '0;
          mem_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating perf counters sampled from the decoded outputs
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((oStallF || oStallD || oStallE || oStallM) && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((oFlushD || oFlushE) && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign oMemTimeout  = mem_timeout_q;
  assign oStallCycles = stall_cnt_q;
  assign oFlushCount  = flush_cnt_q;

endmodule
